mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and load/store.
// Data wins arbitration; one outstanding transaction; timeout returns a NOP.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic [31:0] if_rdata_o,
  output logic        if_valid_o,
  output logic        if_stall_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_be_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_valid_o,
  output logic        mem_stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_err_o
);

  typedef enum logic [2:0] {
    IDLE,
    I_ADDR,
    I_WAIT,
    D_ADDR,
    D_WAIT
  } state_e;

  localparam logic [7:0]  CntMax = 8'(TIMEOUT - 1);
  localparam logic [31:0] Nop    = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic        disc_q, disc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        in_wait, tout, done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      disc_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      be_q    <= be_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    in_wait = (state_q == I_WAIT) || (state_q == D_WAIT);
    tout    = in_wait && !bus_rvalid_i && (cnt_q == CntMax);
    done    = in_wait && (bus_rvalid_i || tout);

    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    be_d        = be_q;
    disc_d      = disc_q;
    cnt_d       = cnt_q;
    if_rdata_o  = '0;
    if_valid_o  = 1'b0;
    mem_rdata_o = '0;
    mem_valid_o = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    bus_be_o    = '0;
    bus_err_o   = tout;

    unique case (state_q)
      IDLE: begin
        disc_d = 1'b0;
        if (mem_req_i) begin
          state_d = D_ADDR;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          we_d    = mem_we_i;
          be_d    = mem_be_i;
        end else if (if_req_i) begin
          state_d = I_ADDR;
          addr_d  = if_addr_i;
          wdata_d = '0;
          we_d    = 1'b0;
          be_d    = 4'hF;
        end
      end
      I_ADDR, D_ADDR: begin
        bus_req_o   = 1'b1;
        bus_we_o    = we_q;
        bus_addr_o  = addr_q;
        bus_wdata_o = wdata_q;
        bus_be_o    = be_q;
        if (state_q == I_ADDR) disc_d = disc_q | if_flush_i;
        if (bus_gnt_i) begin
          state_d = (state_q == I_ADDR) ? I_WAIT : D_WAIT;
          cnt_d   = '0;
        end
      end
      I_WAIT: begin
        disc_d = disc_q | if_flush_i;
        if (done) begin
          if_valid_o = !disc_q && !if_flush_i;
          if_rdata_o = tout ? Nop : bus_rdata_i;
          state_d    = IDLE;
          disc_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      D_WAIT: begin
        if (done) begin
          mem_valid_o = 1'b1;
          mem_rdata_o = tout ? '0 : bus_rdata_i;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if_stall_o  = if_req_i & ~if_valid_o;
    mem_stall_o = mem_req_i & ~mem_valid_o;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Transaction-schedule reference model for mem_port_arbiter.
// Each served request is laid out as idle / address / wait cycles.
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_i, if_flush_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_valid_o, if_stall_o;
  logic        mem_req_i, mem_we_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_rdata_o;
  logic        mem_valid_o, mem_stall_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_be_i(mem_be_i),
    .mem_rdata_o(mem_rdata_o), .mem_valid_o(mem_valid_o),
    .mem_stall_o(mem_stall_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .bus_err_o(bus_err_o)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit chk_en   = 1'b0;

  logic        e_req, e_we, e_ifv, e_memv, e_err, e_chkm;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata, e_ifr, e_memr;

  logic        cap_ifv, cap_memv, cap_err, cap_we;
  logic [31:0] cap_ifr, cap_memr, cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    tot_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("bus_req", 32'(bus_req_o), 32'(e_req));
      chk("bus_we", 32'(bus_we_o), 32'(e_we));
      chk("bus_be", 32'(bus_be_o), 32'(e_be));
      chk("bus_addr", bus_addr_o, e_addr);
      chk("bus_wdata", bus_wdata_o, e_wdata);
      chk("bus_err", 32'(bus_err_o), 32'(e_err));
      chk("if_valid", 32'(if_valid_o), 32'(e_ifv));
      chk("mem_valid", 32'(mem_valid_o), 32'(e_memv));
      chk("if_stall", 32'(if_stall_o), 32'(if_req_i & ~e_ifv));
      chk("mem_stall", 32'(mem_stall_o), 32'(mem_req_i & ~e_memv));
      if (e_ifv) chk("if_rdata", if_rdata_o, e_ifr);
      if (e_memv && e_chkm) chk("mem_rdata", mem_rdata_o, e_memr);
    end
  end

  task automatic clr_exp();
    e_req = 0; e_we = 0; e_be = '0; e_addr = '0; e_wdata = '0;
    e_ifv = 0; e_memv = 0; e_err = 0; e_chkm = 0;
    e_ifr = '0; e_memr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus_rvalid_i = ($urandom_range(0, 3) == 0);
    bus_gnt_i    = $urandom_range(0, 1) != 0;
    bus_rdata_i  = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      clr_exp();
      noise();
      if_flush_i = $urandom_range(0, 1) != 0;
      tick();
    end
    if_flush_i = 0;
  endtask

  // One served request: the IDLE arbitration cycle, g+1 address cycles
  // (grant in the last), then wait cycles until rvalid at wait index r
  // or the timeout at wait index TO-1. fl = cycle index of a flush pulse.
  task automatic serve(input int g, input int r, input int fl,
                       input bit fix, input logic [31:0] fixd);
    bit dat, st, disc, done, tout;
    logic [31:0] a, wd, rd;
    logic [3:0] be;
    int k;
    dat  = mem_req_i;
    st   = dat & mem_we_i;
    a    = dat ? mem_addr_i : if_addr_i;
    wd   = dat ? mem_wdata_i : 32'h0;
    be   = dat ? mem_be_i : 4'hF;
    disc = 0;
    clr_exp();
    noise();
    if_flush_i = (fl == 0);
    tick();
    k = 1;
    for (int i = 0; i <= g; i++) begin
      clr_exp();
      noise();
      bus_gnt_i  = (i == g);
      if_flush_i = (fl == k);
      if (!dat && fl == k) disc = 1;
      e_req = 1; e_we = st; e_be = be; e_addr = a; e_wdata = wd;
      if (i == 0) begin
        #3;
        cap_addr = bus_addr_o; cap_we = bus_we_o;
        cap_be = bus_be_o; cap_wdata = bus_wdata_o;
      end
      tick();
      k++;
    end
    for (int j = 0; j < TO; j++) begin
      clr_exp();
      bus_gnt_i    = $urandom_range(0, 1) != 0;
      bus_rvalid_i = (j == r);
      rd           = fix ? fixd : $urandom;
      bus_rdata_i  = rd;
      if_flush_i   = (fl == k);
      if (!dat && fl == k) disc = 1;
      tout = (j == TO - 1) && (r > j);
      done = (j == r) || tout;
      if (done) begin
        e_err = tout;
        if (dat) begin
          e_memv = 1; e_chkm = !st; e_memr = tout ? 32'h0 : rd;
        end else begin
          e_ifv = !disc; e_ifr = tout ? 32'h13 : rd;
        end
        #3;
        cap_ifv = if_valid_o; cap_ifr = if_rdata_o;
        cap_memv = mem_valid_o; cap_memr = mem_rdata_o;
        cap_err = bus_err_o;
        tick();
        if (dat) mem_req_i = 0;
        else if_req_i = 0;
        bus_rvalid_i = 0; bus_gnt_i = 0; if_flush_i = 0;
        clr_exp();
        break;
      end
      tick();
      k++;
    end
  endtask

  task automatic set_fetch(input logic [31:0] a);
    if_req_i = 1; if_addr_i = a;
  endtask

  task automatic set_data(input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    mem_req_i = 1; mem_we_i = we; mem_addr_i = a;
    mem_wdata_i = wd; mem_be_i = be;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, g, r, fl;
    rst_n = 0;
    if_req_i = 0; if_addr_i = '0; if_flush_i = 0;
    mem_req_i = 0; mem_we_i = 0; mem_addr_i = '0;
    mem_wdata_i = '0; mem_be_i = '0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0;
    clr_exp();
    chk_en = 1;
    tick();
    tick();
    rst_n = 1;
    idle(2);

    // fetch 0x100, grant after 1 cycle, rvalid 2 wait cycles later
    set_fetch(32'h100);
    serve(1, 2, -1, 1, 32'h0050_0093);
    chk("f100_addr", cap_addr, 32'h100);
    chk("f100_be", 32'(cap_be), 32'hF);
    chk("f100_ifv", 32'(cap_ifv), 32'h1);
    chk("f100_rdata", cap_ifr, 32'h0050_0093);
    idle(1);

    // simultaneous fetch and load: data first
    set_fetch(32'h104);
    set_data(0, 32'h2000, 32'h0, 4'hF);
    serve(0, 1, -1, 0, 32'h0);
    chk("both_addr", cap_addr, 32'h2000);
    chk("both_memv", 32'(cap_memv), 32'h1);
    chk("both_ifv", 32'(cap_ifv), 32'h0);
    serve(0, 0, -1, 0, 32'h0);
    chk("both_f_addr", cap_addr, 32'h104);
    chk("both_f_ifv", 32'(cap_ifv), 32'h1);

    // store with partial byte enables
    set_data(1, 32'h3004, 32'hDEAD_BEEF, 4'b0011);
    serve(2, 1, -1, 0, 32'h0);
    chk("st_we", 32'(cap_we), 32'h1);
    chk("st_be", 32'(cap_be), 32'h3);
    chk("st_wdata", cap_wdata, 32'hDEAD_BEEF);
    chk("st_memv", 32'(cap_memv), 32'h1);

    // flush during wait suppresses fetch; next fetch is normal
    set_fetch(32'h200);
    serve(0, 3, 3, 0, 32'h0);
    chk("fl_ifv", 32'(cap_ifv), 32'h0);
    set_fetch(32'h400);
    serve(1, 0, -1, 0, 32'h0);
    chk("fl_next_ifv", 32'(cap_ifv), 32'h1);

    // flush coinciding with rvalid
    set_fetch(32'h500);
    serve(0, 0, 2, 0, 32'h0);
    chk("fl_coin_ifv", 32'(cap_ifv), 32'h0);

    // flush in IDLE has no effect
    set_fetch(32'h600);
    serve(0, 1, 0, 0, 32'h0);
    chk("fl_idle_ifv", 32'(cap_ifv), 32'h1);

    // fetch timeout returns NOP
    set_fetch(32'h700);
    serve(0, 50, -1, 0, 32'h0);
    chk("to_err", 32'(cap_err), 32'h1);
    chk("to_ifv", 32'(cap_ifv), 32'h1);
    chk("to_ifr", cap_ifr, 32'h13);
    idle(1);

    // load timeout returns zero
    set_data(0, 32'h800, 32'h0, 4'hF);
    serve(1, 50, -1, 0, 32'h0);
    chk("to_d_err", 32'(cap_err), 32'h1);
    chk("to_d_memr", cap_memr, 32'h0);

    // reset during D_WAIT, then a late rvalid
    set_data(0, 32'h5000, 32'h0, 4'hF);
    clr_exp();
    tick();
    clr_exp();
    bus_gnt_i = 1;
    e_req = 1; e_be = 4'hF; e_addr = 32'h5000;
    tick();
    clr_exp();
    bus_gnt_i = 0;
    tick();
    rst_n = 0;
    mem_req_i = 0;
    clr_exp();
    tick();
    tick();
    rst_n = 1;
    tick();
    bus_rvalid_i = 1;
    bus_rdata_i = 32'hCAFE_F00D;
    tick();
    bus_rvalid_i = 0;
    tick();

    for (int it = 0; it < 300; it++) begin
      mode = $urandom_range(0, 3);
      if (mode == 0 || mode == 3) set_fetch({$urandom_range(0, 65535), 2'b00});
      if (mode != 0)
        set_data(mode == 2, $urandom, $urandom, 4'($urandom_range(0, 15)));
      g  = $urandom_range(0, 3);
      r  = $urandom_range(0, TO + 1);
      fl = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, g + r + 2)) : -1;
      serve(g, r, fl, 0, 32'h0);
      if (mode == 3) begin
        g  = $urandom_range(0, 3);
        r  = $urandom_range(0, TO + 1);
        fl = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, g + r + 2)) : -1;
        serve(g, r, fl, 0, 32'h0);
      end
      idle($urandom_range(0, 2));
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
